// File: rtl/booth_pp_accum.sv
// Radix-4 Booth partial-product accumulator: consumes LSB-first Booth select codes and returns the signed 2*WIDTH product.
// Optional illegal-code flag enabled by defining BOOTH_PP_ACCUM_CHK_EN; otherwise err is tied low.
module booth_pp_accum #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic                 sel_valid,
    input  logic [2:0]           sel,
    output logic                 sel_ready,
    output logic                 busy,
    output logic                 prod_valid,
    input  logic                 prod_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 err
);

    localparam int GROUPS = WIDTH / 2;
    localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int PW     = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [PW-1:0]      r_acc;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_start_acc;
    logic               w_beat;
    logic               w_last;
    logic [PW-1:0]      w_a_ext;
    logic [PW-1:0]      w_a2_ext;
    logic [PW-1:0]      w_pp;
    logic [PW-1:0]      w_pp_shift;

    assign w_last = (r_cnt == CNT_W'(GROUPS - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_beat      = 1'b0;
        sel_ready   = 1'b0;
        busy        = 1'b0;
        prod_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                sel_ready = 1'b1;
                busy      = 1'b1;
                if (sel_valid) begin
                    w_beat = 1'b1;
                    if (w_last) w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                prod_valid = 1'b1;
                if (prod_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // 2A is built at WIDTH+1 bits before extension so A = -2^(WIDTH-1) doubles correctly.
    assign w_a_ext  = {{WIDTH{r_a[WIDTH-1]}}, r_a};
    assign w_a2_ext = {{(WIDTH-1){r_a[WIDTH-1]}}, r_a, 1'b0};

    always_comb begin
        w_pp = '0;
        case (sel)
            3'd1:    w_pp = -w_a2_ext;
            3'd2:    w_pp = -w_a_ext;
            3'd4:    w_pp = w_a_ext;
            3'd5:    w_pp = w_a2_ext;
            default: w_pp = '0;
        endcase
    end

    assign w_pp_shift = w_pp << {r_cnt, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_start_acc) begin
            r_a   <= mcand;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_beat) begin
            r_acc <= r_acc + w_pp_shift;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign product = r_acc;

`ifdef BOOTH_PP_ACCUM_CHK_EN
    logic r_err;
    logic w_illegal;

    assign w_illegal = (sel == 3'd0) || (sel == 3'd6) || (sel == 3'd7);

    // Sticky until the next accepted start so the flag survives the DONE handshake.
    always_ff @(posedge clk) begin
        if (rst)                        r_err <= 1'b0;
        else if (w_start_acc)           r_err <= 1'b0;
        else if (w_beat && w_illegal)   r_err <= 1'b1;
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_booth_pp_accum.sv
// Self-checking bench for booth_pp_accum: directed plan cases plus randomized products against an arithmetic model.
module tb_booth_pp_accum;

    localparam int WIDTH  = 8;
    localparam int GROUPS = WIDTH / 2;
    localparam int PW     = 2 * WIDTH;

`ifdef BOOTH_PP_ACCUM_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [WIDTH-1:0]    mcand;
    logic                sel_valid;
    logic [2:0]          sel;
    logic                sel_ready;
    logic                busy;
    logic                prod_valid;
    logic                prod_ready;
    logic [PW-1:0]       product;
    logic                err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    booth_pp_accum #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mcand      (mcand),
        .sel_valid  (sel_valid),
        .sel        (sel),
        .sel_ready  (sel_ready),
        .busy       (busy),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .product    (product),
        .err        (err)
    );

    // Reference: each code is a digit in {-2,-1,0,+1,+2} weighted by 4^i; product = A * sum.
    function automatic logic [PW-1:0] model_prod(input logic [WIDTH-1:0] a, input logic [3*GROUPS-1:0] codes);
        longint acc = 0;
        longint d;
        for (int i = 0; i < GROUPS; i++) begin
            case (codes[3*i +: 3])
                3'd1:    d = -2;
                3'd2:    d = -1;
                3'd4:    d = 1;
                3'd5:    d = 2;
                default: d = 0;
            endcase
            acc = acc + d * longint'($signed(a)) * (longint'(1) << (2 * i));
        end
        return acc[PW-1:0];
    endfunction

    function automatic bit model_err(input logic [3*GROUPS-1:0] codes);
        bit bad = 1'b0;
        for (int i = 0; i < GROUPS; i++)
            if (codes[3*i +: 3] == 3'd0 || codes[3*i +: 3] > 3'd5) bad = 1'b1;
        return bad & CHK;
    endfunction

    function automatic logic [3*GROUPS-1:0] pack4(input logic [2:0] c0, c1, c2, c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues start then all codes (LSB group first) with up to gap_max idle cycles before each beat.
    task automatic feed(input logic [WIDTH-1:0] a, input logic [3*GROUPS-1:0] codes,
                        input int gap_max, output int cycles);
        int g;
        start = 1'b1;
        mcand = a;
        tick();
        start  = 1'b0;
        mcand  = WIDTH'($urandom);
        cycles = 1;
        for (int i = 0; i < GROUPS; i++) begin
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            sel_valid = 1'b0;
            sel       = 3'($urandom_range(7, 0));
            repeat (g) begin
                tick();
                cycles++;
            end
            sel_valid = 1'b1;
            sel       = codes[3*i +: 3];
            tick();
            cycles++;
        end
        sel_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (prod_valid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        n_tests++;
        if (prod_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s prod_valid timeout: got %b want 1", name, prod_valid);
        end
    endtask

    task automatic accept_and_check(input string name);
        prod_ready = 1'b1;
        tick();
        prod_ready = 1'b0;
        n_tests++;
        if (prod_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s return to idle: prod_valid=%b busy=%b want 0 0", name, prod_valid, busy);
        end
    endtask

    task automatic run_product(input string name, input logic [WIDTH-1:0] a,
                               input logic [3*GROUPS-1:0] codes, input int gap_max, input bit chk_lat);
        int cycles;
        logic [PW-1:0] exp_p;
        exp_p = model_prod(a, codes);
        feed(a, codes, gap_max, cycles);
        if (chk_lat) begin
            n_tests++;
            if (prod_valid !== 1'b1 || cycles != GROUPS + 1) begin
                n_fail++;
                $display("FAIL %s latency: prod_valid=%b after %0d cycles want 1 after %0d",
                         name, prod_valid, cycles, GROUPS + 1);
            end
        end
        wait_done(name);
        n_tests++;
        if (product !== exp_p) begin
            n_fail++;
            $display("FAIL %s product: got %h want %h", name, product, exp_p);
        end
        n_tests++;
        if (err !== model_err(codes)) begin
            n_fail++;
            $display("FAIL %s err: got %b want %b", name, err, model_err(codes));
        end
        accept_and_check(name);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; mcand = 8'h55; sel_valid = 1'b1; sel = 3'd5; prod_ready = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({sel_ready, busy, prod_valid, err} !== 4'b0 || product !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: rdy=%b busy=%b pv=%b err=%b prod=%h want all 0",
                     sel_ready, busy, prod_valid, err, product);
        end
        rst = 1'b0; start = 1'b0; sel_valid = 1'b0;
        tick();
        n_tests++;
        if (busy !== 1'b0 || sel_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset idle: busy=%b sel_ready=%b want 0 0", busy, sel_ready);
        end
    endtask

    task automatic test_directed();
        run_product("b5",     8'd3,   pack4(3'd4, 3'd4, 3'd3, 3'd3), 0, 1'b1);
        run_product("neg128", 8'h80,  pack4(3'd3, 3'd3, 3'd3, 3'd1), 0, 1'b1);
        run_product("neg1",   8'd127, pack4(3'd2, 3'd3, 3'd3, 3'd3), 0, 1'b1);
    endtask

    task automatic test_gaps_and_hold();
        int cycles;
        logic [PW-1:0] held;
        sel_valid = 1'b1;
        sel       = 3'd5;
        repeat (2) tick();
        n_tests++;
        if (busy !== 1'b0 || sel_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle codes: busy=%b sel_ready=%b want 0 0", busy, sel_ready);
        end
        sel_valid = 1'b0;
        feed(8'd3, pack4(3'd4, 3'd4, 3'd3, 3'd3), 3, cycles);
        wait_done("gaps");
        held = 16'h000F;
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            mcand = 8'd77;
            tick();
            n_tests++;
            if (prod_valid !== 1'b1 || product !== held) begin
                n_fail++;
                $display("FAIL hold cycle %0d: pv=%b product=%h want 1 %h", i, prod_valid, product, held);
            end
        end
        prod_ready = 1'b1;
        tick();
        prod_ready = 1'b0;
        start      = 1'b0;
        n_tests++;
        if (prod_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL hold release: pv=%b busy=%b want 0 0", prod_valid, busy);
        end
        tick();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start in done ignored: busy=%b want 0", busy);
        end
    endtask

    task automatic test_illegal();
        int cycles;
        feed(8'd3, pack4(3'd4, 3'd6, 3'd3, 3'd3), 0, cycles);
        wait_done("illegal");
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (product !== 16'h0003 || err !== CHK) begin
                n_fail++;
                $display("FAIL illegal hold %0d: product=%h err=%b want 0003 %b", i, product, err, CHK);
            end
            tick();
        end
        accept_and_check("illegal");
        run_product("after_illegal", 8'd1, pack4(3'd4, 3'd3, 3'd3, 3'd3), 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        mcand = 8'd9;
        tick();
        start = 1'b0;
        n_tests++;
        if (sel_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL run entry: sel_ready=%b busy=%b want 1 1", sel_ready, busy);
        end
        sel_valid = 1'b1;
        sel       = 3'd5;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sel_valid = 1'b0;
        n_tests++;
        if ({busy, sel_ready, prod_valid} !== 3'b0 || product !== '0) begin
            n_fail++;
            $display("FAIL reset mid-op: busy=%b rdy=%b pv=%b product=%h want 0 0 0 0000",
                     busy, sel_ready, prod_valid, product);
        end
        run_product("after_reset", 8'd3, pack4(3'd4, 3'd4, 3'd3, 3'd3), 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_product("b2b0", 8'hF3, pack4(3'd5, 3'd1, 3'd2, 3'd4), 0, 1'b1);
        run_product("b2b1", 8'h80, pack4(3'd1, 3'd5, 3'd1, 3'd5), 0, 1'b1);
        run_product("b2b2", 8'h7F, pack4(3'd5, 3'd5, 3'd5, 3'd5), 0, 1'b1);
    endtask

    task automatic test_random();
        logic [3*GROUPS-1:0] codes;
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < GROUPS; i++)
                codes[3*i +: 3] = ($urandom_range(9, 0) == 0) ? 3'($urandom_range(7, 6))
                                                             : 3'($urandom_range(5, 1));
            repeat ($urandom_range(2, 0)) tick();
            run_product("random", WIDTH'($urandom), codes, 2, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_gaps_and_hold();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
